pga_spi_responder: RTL and testbench

//  SPI slave that receives MCP6S91-format 16-bit command frames (SPI mode 0,0, MSB first) on SPI_nCS/SPI_SI/SPI_SCK.

---
 rtl/pga_spi_pkg.sv | 29 ++
 rtl/spi_pin_sync.sv | 36 +++
 rtl/pga_spi_responder.sv | 171 +++++++++++++++++
 tb/tb_pga_spi_responder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pga_spi_pkg.sv
// pga_spi_pkg: shared definitions for the PGA SPI control link.
//  - MCP6S91 command / address field encodings
//  - error code and responder state enumerations
//  - nominal frame length
package pga_spi_pkg;

  localparam int unsigned PGA_FRAME_BITS = 16;

  localparam logic [2:0] CMD_NOP   = 3'b000;
  localparam logic [2:0] CMD_WRITE = 3'b010;
  localparam logic [2:0] CMD_SHDN  = 3'b001;

  localparam logic ADDR_GAIN = 1'b0;
  localparam logic ADDR_CHAN = 1'b1;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_COUNT = 2'b01,
    ERR_CMD   = 2'b10
  } err_code_e;

  typedef enum logic [1:0] {
    ARM,
    IDLE,
    SHIFT,
    DECODE
  } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: synchroniser for one asynchronous SPI pin into the clk domain.
//  clk   in  system clock
//  pin   in  asynchronous pin
//  level out synchronised level (after Stages flops)
//  rise  out one-cycle pulse on a synchronised 0->1 transition
//  fall  out one-cycle pulse on a synchronised 1->0 transition
// The chain is deliberately not reset: it must keep tracking the real pin
// level through a reset so the responder can tell a frame already in flight.
module spi_pin_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[Stages-2:0], pin};
    hist_d = sync_q[Stages-1];
  end

  always_ff @(posedge clk) begin
    sync_q <= sync_d;
    hist_q <= hist_d;
  end

  assign level = sync_q[Stages-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/pga_spi_responder.sv
// pga_spi_responder: SPI mode 0,0 slave decoding MCP6S91 16-bit command frames
// into gain / channel / shutdown state.
//  Clk       in   system clock
//  Reset     in   synchronous active-high reset
//  SPI_nCS   in   chip select, active low (async)
//  SPI_SI    in   serial data, MSB first (async)
//  SPI_SCK   in   serial clock (async), sampled on rising edge
//  Gain      out  current gain code
//  Channel   out  current input channel code
//  Shutdown  out  shutdown mode latched
//  Update    out  one-cycle pulse: valid frame applied
//  Err       out  one-cycle pulse: frame rejected
//  ErrCode   out  reason while Err=1 (01 bit count, 10 unknown command)
module pga_spi_responder
  import pga_spi_pkg::*;
#(
  parameter int unsigned FrameBits  = PGA_FRAME_BITS,
  parameter int unsigned SyncStages = 2,
  parameter logic [2:0]  GainInit   = 3'd0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       SPI_nCS,
  input  logic       SPI_SI,
  input  logic       SPI_SCK,
  output logic [2:0] Gain,
  output logic [2:0] Channel,
  output logic       Shutdown,
  output logic       Update,
  output logic       Err,
  output logic [1:0] ErrCode
);

  localparam int unsigned   CntW     = $clog2(FrameBits + 2);
  localparam logic [CntW-1:0] CntFrame = CntW'(FrameBits);
  localparam logic [CntW-1:0] CntMax   = CntW'(FrameBits + 1);

  logic ncs_level, ncs_rise, ncs_fall_unused;
  logic sck_level_unused, sck_rise, sck_fall_unused;
  logic si_level, si_rise_unused, si_fall_unused;

  spi_pin_sync #(.Stages(SyncStages)) u_sync_ncs (
    .clk   (Clk),
    .pin   (SPI_nCS),
    .level (ncs_level),
    .rise  (ncs_rise),
    .fall  (ncs_fall_unused)
  );

  spi_pin_sync #(.Stages(SyncStages)) u_sync_sck (
    .clk   (Clk),
    .pin   (SPI_SCK),
    .level (sck_level_unused),
    .rise  (sck_rise),
    .fall  (sck_fall_unused)
  );

  spi_pin_sync #(.Stages(SyncStages)) u_sync_si (
    .clk   (Clk),
    .pin   (SPI_SI),
    .level (si_level),
    .rise  (si_rise_unused),
    .fall  (si_fall_unused)
  );

  state_e               state_q, state_d;
  logic [FrameBits-1:0] sr_q, sr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           gain_q, gain_d;
  logic [2:0]           chan_q, chan_d;
  logic                 shdn_q, shdn_d;
  logic                 update_q, update_d;
  logic                 err_q, err_d;
  err_code_e            err_code_q, err_code_d;

  // Decode is evaluated on the SHIFT->DECODE transition from the next-state
  // shift register and count, so a final SCK rise coinciding with the nCS rise
  // is included and the registered pulses are high during the DECODE cycle.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    gain_d     = gain_q;
    chan_d     = chan_q;
    shdn_d     = shdn_q;
    update_d   = 1'b0;
    err_d      = 1'b0;
    err_code_d = ERR_NONE;

    case (state_q)
      ARM: begin
        if (ncs_level) state_d = IDLE;
      end
      IDLE: begin
        // Level, not edge: a fall that landed during DECODE still starts a frame.
        if (!ncs_level) begin
          sr_d    = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sck_rise) begin
          sr_d = {sr_q[FrameBits-2:0], si_level};
          if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
        end
        if (ncs_rise) begin
          state_d = DECODE;
          if (cnt_d != CntFrame) begin
            err_d      = 1'b1;
            err_code_d = ERR_COUNT;
          end else begin
            case (sr_d[15:13])
              CMD_NOP: ;
              CMD_WRITE: begin
                if (sr_d[8] == ADDR_GAIN) gain_d = sr_d[2:0];
                else                      chan_d = sr_d[2:0];
                shdn_d   = 1'b0;
                update_d = 1'b1;
              end
              CMD_SHDN: begin
                shdn_d   = 1'b1;
                update_d = 1'b1;
              end
              default: begin
                err_d      = 1'b1;
                err_code_d = ERR_CMD;
              end
            endcase
          end
        end
      end
      DECODE: begin
        state_d = IDLE;
      end
      default: state_d = ARM;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ARM;
      sr_q       <= '0;
      cnt_q      <= '0;
      gain_q     <= GainInit;
      chan_q     <= '0;
      shdn_q     <= 1'b0;
      update_q   <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      gain_q     <= gain_d;
      chan_q     <= chan_d;
      shdn_q     <= shdn_d;
      update_q   <= update_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign Gain     = gain_q;
  assign Channel  = chan_q;
  assign Shutdown = shdn_q;
  assign Update   = update_q;
  assign Err      = err_q;
  assign ErrCode  = err_code_q;

endmodule

// File: tb/tb_pga_spi_responder.sv
// tb_pga_spi_responder: directed frames at 1 MHz SCK against pga_spi_responder.
// Expected Update/Err events (with the output state after each) are queued as
// frames are sent; a monitor pops and compares on every Update or Err pulse.
`timescale 1ns/1ps
module tb_pga_spi_responder;

  localparam realtime HALF = 500.0;   // 1 MHz SCK
  localparam realtime GAP  = 2000.0;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       SPI_nCS = 1'b1;
  logic       SPI_SI = 1'b0;
  logic       SPI_SCK = 1'b0;
  logic [2:0] Gain;
  logic [2:0] Channel;
  logic       Shutdown;
  logic       Update;
  logic       Err;
  logic [1:0] ErrCode;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       is_err;
    logic [1:0] code;
    logic [2:0] gain;
    logic [2:0] chan;
    logic       shdn;
  } exp_t;

  exp_t sb_q[$];

  pga_spi_responder #(
    .FrameBits  (16),
    .SyncStages (2),
    .GainInit   (3'd0)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .SPI_nCS  (SPI_nCS),
    .SPI_SI   (SPI_SI),
    .SPI_SCK  (SPI_SCK),
    .Gain     (Gain),
    .Channel  (Channel),
    .Shutdown (Shutdown),
    .Update   (Update),
    .Err      (Err),
    .ErrCode  (ErrCode)
  );

  always #2.5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic is_err, input logic [1:0] code,
                      input logic [2:0] g, input logic [2:0] c, input logic s);
    exp_t e;
    e.is_err = is_err;
    e.code   = code;
    e.gain   = g;
    e.chan   = c;
    e.shdn   = s;
    sb_q.push_back(e);
  endtask

  task automatic send_bits(input logic [31:0] val, input int unsigned n);
    for (int unsigned i = n; i > 0; i--) begin
      SPI_SI = val[i-1];
      #(HALF);
      SPI_SCK = 1'b1;
      #(HALF);
      SPI_SCK = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] val, input int unsigned n);
    SPI_nCS = 1'b0;
    #(HALF);
    send_bits(val, n);
    #(HALF);
    SPI_nCS = 1'b1;
    #(GAP);
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge Clk) begin
    if (!Reset && (Update || Err)) begin
      check("pulse_exclusive", {31'd0, Update & Err}, 32'd0);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: Update=%0b Err=%0b ErrCode=%0d, expected no pulse",
                 Update, Err, ErrCode);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("pulse_kind_err", {31'd0, Err}, {31'd0, e.is_err});
        check("err_code", {30'd0, ErrCode}, {30'd0, e.code});
        check("gain", {29'd0, Gain}, {29'd0, e.gain});
        check("channel", {29'd0, Channel}, {29'd0, e.chan});
        check("shutdown", {31'd0, Shutdown}, {31'd0, e.shdn});
      end
    end
  end

  initial begin
    repeat (10) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("rst_gain", {29'd0, Gain}, 32'd0);
    check("rst_channel", {29'd0, Channel}, 32'd0);
    check("rst_shutdown", {31'd0, Shutdown}, 32'd0);
    check("rst_update", {31'd0, Update}, 32'd0);
    check("rst_err", {31'd0, Err}, 32'd0);
    check("rst_errcode", {30'd0, ErrCode}, 32'd0);
    #(GAP);

    // 1. gain write
    push(1'b0, 2'b00, 3'd5, 3'd0, 1'b0);
    frame(32'h4005, 16);
    // 2. channel write, gain kept
    push(1'b0, 2'b00, 3'd5, 3'd3, 1'b0);
    frame(32'h4103, 16);
    // 3. shutdown, then a gain write clears it
    push(1'b0, 2'b00, 3'd5, 3'd3, 1'b1);
    frame(32'h2000, 16);
    push(1'b0, 2'b00, 3'd2, 3'd3, 1'b0);
    frame(32'h4002, 16);
    // 4. 15-bit and 17-bit frames carrying 0x4007
    push(1'b1, 2'b01, 3'd2, 3'd3, 1'b0);
    frame(32'h4007 >> 1, 15);
    push(1'b1, 2'b01, 3'd2, 3'd3, 1'b0);
    frame(32'h4007 << 1, 17);
    // 5. unknown command, then NOP (no event expected)
    push(1'b1, 2'b10, 3'd2, 3'd3, 1'b0);
    frame(32'hE005, 16);
    frame(32'h0000, 16);

    // 6. reset in the middle of a frame
    SPI_nCS = 1'b0;
    #(HALF);
    send_bits(32'h40, 8);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("midrst_gain", {29'd0, Gain}, 32'd0);
    check("midrst_channel", {29'd0, Channel}, 32'd0);
    check("midrst_shutdown", {31'd0, Shutdown}, 32'd0);
    send_bits(32'h06, 8);
    #(HALF);
    SPI_nCS = 1'b1;
    #(GAP);
    push(1'b0, 2'b00, 3'd6, 3'd0, 1'b0);
    frame(32'h4006, 16);
    // reserved bits set, still a gain write of 2
    push(1'b0, 2'b00, 3'd2, 3'd0, 1'b0);
    frame(32'h5EFA, 16);

    for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(negedge Clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
